// File: rtl/mm_port_arbiter_if.sv
// Bus bundle for mm_port_arbiter: two core-side OBI ports plus the shared memory port.
// The slave modport is the arbiter's view; master is the environment (core and memory) view.
interface mm_port_arbiter_if;
  logic        m0_req_i;
  logic [31:0] m0_addr_i;
  logic        m0_gnt_o;
  logic        m0_rvalid_o;
  logic [31:0] m0_rdata_o;

  logic        m1_req_i;
  logic [31:0] m1_addr_i;
  logic        m1_we_i;
  logic [3:0]  m1_be_i;
  logic [31:0] m1_wdata_i;
  logic        m1_gnt_o;
  logic        m1_rvalid_o;
  logic [31:0] m1_rdata_o;

  logic        s_req_o;
  logic [31:0] s_addr_o;
  logic        s_we_o;
  logic [3:0]  s_be_o;
  logic [31:0] s_wdata_o;
  logic        s_gnt_i;
  logic        s_rvalid_i;
  logic [31:0] s_rdata_i;

  modport slave (
    input  m0_req_i, m0_addr_i,
    output m0_gnt_o, m0_rvalid_o, m0_rdata_o,
    input  m1_req_i, m1_addr_i, m1_we_i, m1_be_i, m1_wdata_i,
    output m1_gnt_o, m1_rvalid_o, m1_rdata_o,
    output s_req_o, s_addr_o, s_we_o, s_be_o, s_wdata_o,
    input  s_gnt_i, s_rvalid_i, s_rdata_i
  );

  modport master (
    output m0_req_i, m0_addr_i,
    input  m0_gnt_o, m0_rvalid_o, m0_rdata_o,
    output m1_req_i, m1_addr_i, m1_we_i, m1_be_i, m1_wdata_i,
    input  m1_gnt_o, m1_rvalid_o, m1_rdata_o,
    input  s_req_o, s_addr_o, s_we_o, s_be_o, s_wdata_o,
    output s_gnt_i, s_rvalid_i, s_rdata_i
  );
endinterface

// File: rtl/mm_port_arbiter.sv
// Two-master OBI arbiter onto one memory port, with an in-order owner FIFO for response routing.
// Define MM_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise data (master 1) has fixed priority.
module mm_port_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  mm_port_arbiter_if.slave bus,
  output logic [CNT_W-1:0] outstanding_o,
  output logic             err_o
);

  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  typedef enum logic {ST_IDLE, ST_LOCKED} lock_state_t;

  lock_state_t                r_state;
  logic                       r_owner;
  logic [MAX_OUTSTANDING-1:0] r_fifo;
  logic [PTR_W-1:0]           r_wptr;
  logic [PTR_W-1:0]           r_rptr;
  logic [CNT_W-1:0]           r_count;
  logic                       r_err;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_arb;
  logic w_sel;
  logic w_sel_req;
  logic w_accept;
  logic w_head;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_W'(MAX_OUTSTANDING));
  assign w_pop   = !rst_i && bus.s_rvalid_i && !w_empty;
  assign w_head  = r_fifo[r_rptr];

`ifdef MM_ARB_ROUND_ROBIN_EN
  logic r_prio;
  // On a tie the pointer's master wins; otherwise whoever is requesting.
  assign w_arb = (bus.m0_req_i && bus.m1_req_i) ? r_prio : bus.m1_req_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_prio <= 1'b0;
    end else if (w_accept) begin
      r_prio <= ~w_sel;
    end
  end
`else
  assign w_arb = bus.m1_req_i;
`endif

  assign w_sel     = (r_state == ST_LOCKED) ? r_owner : w_arb;
  assign w_sel_req = w_sel ? bus.m1_req_i : bus.m0_req_i;
  // When full, a response arriving this cycle frees a slot, so a request may still go out.
  assign w_accept  = bus.s_req_o && bus.s_gnt_i;

  always_comb begin
    bus.s_req_o   = !rst_i && w_sel_req && (!w_full || bus.s_rvalid_i);
    bus.s_addr_o  = rst_i ? 32'h0 : (w_sel ? bus.m1_addr_i : bus.m0_addr_i);
    bus.s_we_o    = !rst_i && w_sel && bus.m1_we_i;
    bus.s_be_o    = rst_i ? 4'h0 : (w_sel ? bus.m1_be_i : 4'hF);
    bus.s_wdata_o = (!rst_i && w_sel) ? bus.m1_wdata_i : 32'h0;
  end

  assign bus.m0_gnt_o    = w_accept && !w_sel;
  assign bus.m1_gnt_o    = w_accept && w_sel;
  assign bus.m0_rvalid_o = w_pop && !w_head;
  assign bus.m1_rvalid_o = w_pop && w_head;
  assign bus.m0_rdata_o  = bus.s_rdata_i;
  assign bus.m1_rdata_o  = bus.s_rdata_i;

  assign outstanding_o = rst_i ? '0 : r_count;
  assign err_o         = !rst_i && r_err;

  // Lock holds the selected owner from an ungranted request until its grant.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_owner <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.s_req_o && !bus.s_gnt_i) begin
            r_state <= ST_LOCKED;
            r_owner <= w_sel;
          end
        end
        ST_LOCKED: begin
          if (bus.s_gnt_i) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < MAX_OUTSTANDING; gi++) begin : g_fifo
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          r_fifo[gi] <= 1'b0;
        end else if (w_accept && (r_wptr == PTR_W'(gi))) begin
          r_fifo[gi] <= w_sel;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wptr <= (r_wptr == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : r_rptr + 1'b1;
      end
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (bus.s_rvalid_i && w_empty) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mm_port_arbiter.sv
// Directed bench for mm_port_arbiter: fetch, contention, lock, full/in-order, error and reset cases.
// Expected grant order follows MM_ARB_ROUND_ROBIN_EN when that macro is defined for the build.
module tb_mm_port_arbiter;

  logic       clk;
  logic       rst;
  logic [1:0] outstanding;
  logic       err;
  int         n_checks;
  int         n_errors;

  mm_port_arbiter_if bus ();

  mm_port_arbiter #(.MAX_OUTSTANDING(2)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .bus           (bus.slave),
    .outstanding_o (outstanding),
    .err_o         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Advance to just after the next rising edge, where inputs are changed.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.m0_req_i   = 1'b0;
    bus.m0_addr_i  = 32'h100;
    bus.m1_req_i   = 1'b0;
    bus.m1_addr_i  = 32'h200;
    bus.m1_we_i    = 1'b1;
    bus.m1_be_i    = 4'h3;
    bus.m1_wdata_i = 32'hDEAD_BEEF;
    bus.s_gnt_i    = 1'b0;
    bus.s_rvalid_i = 1'b0;
    bus.s_rdata_i  = 32'h0;
  endtask

  task automatic do_reset();
    tick();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic single_fetch(input string tag);
    bus.m0_req_i  = 1'b1;
    bus.m0_addr_i = 32'h80;
    bus.s_gnt_i   = 1'b1;
    #1;
    check({tag, "_s_addr"}, bus.s_addr_o, 32'h80);
    check({tag, "_s_be"}, {28'h0, bus.s_be_o}, 32'hF);
    check({tag, "_s_we"}, {31'h0, bus.s_we_o}, 32'h0);
    check({tag, "_m0_gnt"}, {31'h0, bus.m0_gnt_o}, 32'h1);
    check({tag, "_m1_gnt"}, {31'h0, bus.m1_gnt_o}, 32'h0);
    tick();
    bus.m0_req_i   = 1'b0;
    bus.s_gnt_i    = 1'b0;
    bus.s_rvalid_i = 1'b1;
    bus.s_rdata_i  = 32'h0000_0413;
    #1;
    check({tag, "_out_before"}, {30'h0, outstanding}, 32'h1);
    check({tag, "_m0_rvalid"}, {31'h0, bus.m0_rvalid_o}, 32'h1);
    check({tag, "_m1_rvalid"}, {31'h0, bus.m1_rvalid_o}, 32'h0);
    check({tag, "_m0_rdata"}, bus.m0_rdata_o, 32'h0000_0413);
    tick();
    bus.s_rvalid_i = 1'b0;
    #1;
    check({tag, "_out_after"}, {30'h0, outstanding}, 32'h0);
  endtask

  logic exp_win;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    idle_inputs();

    // Outputs during reset, even with a granted request present.
    bus.m0_req_i = 1'b1;
    bus.s_gnt_i  = 1'b1;
    #2;
    check("rst_s_req", {31'h0, bus.s_req_o}, 32'h0);
    check("rst_m0_gnt", {31'h0, bus.m0_gnt_o}, 32'h0);
    check("rst_s_addr", bus.s_addr_o, 32'h0);
    check("rst_s_be", {28'h0, bus.s_be_o}, 32'h0);
    check("rst_outstanding", {30'h0, outstanding}, 32'h0);
    check("rst_err", {31'h0, err}, 32'h0);
    tick();
    tick();
    idle_inputs();
    rst = 1'b0;

    single_fetch("fetch");

    // Contention: both masters request every cycle, responses drain one per cycle.
    do_reset();
    for (int i = 0; i < 4; i++) begin
`ifdef MM_ARB_ROUND_ROBIN_EN
      exp_win = (i % 2 == 1);
`else
      exp_win = 1'b1;
`endif
      bus.m0_req_i   = 1'b1;
      bus.m1_req_i   = 1'b1;
      bus.s_gnt_i    = 1'b1;
      bus.s_rvalid_i = (i != 0);
      #1;
      check($sformatf("cont%0d_m0_gnt", i), {31'h0, bus.m0_gnt_o}, {31'h0, ~exp_win});
      check($sformatf("cont%0d_m1_gnt", i), {31'h0, bus.m1_gnt_o}, {31'h0, exp_win});
      check($sformatf("cont%0d_s_addr", i), bus.s_addr_o, exp_win ? 32'h200 : 32'h100);
      check($sformatf("cont%0d_s_we", i), {31'h0, bus.s_we_o}, {31'h0, exp_win});
      tick();
    end
    bus.m0_req_i = 1'b0;
    bus.m1_req_i = 1'b0;
    bus.s_gnt_i  = 1'b0;
    tick();
    bus.s_rvalid_i = 1'b0;
    #1;
    check("cont_drained", {30'h0, outstanding}, 32'h0);

    // Lock: master 0 waits ungranted; master 1 arriving must not steal the port.
    do_reset();
    bus.m0_req_i  = 1'b1;
    bus.m0_addr_i = 32'h40;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("lock%0d_s_addr", i), bus.s_addr_o, 32'h40);
      tick();
    end
    bus.m1_req_i = 1'b1;
    #1;
    check("lock_m1_arrive_addr", bus.s_addr_o, 32'h40);
    check("lock_m1_arrive_req", {31'h0, bus.s_req_o}, 32'h1);
    tick();
    bus.s_gnt_i = 1'b1;
    #1;
    check("lock_m0_gnt", {31'h0, bus.m0_gnt_o}, 32'h1);
    check("lock_m1_gnt_blocked", {31'h0, bus.m1_gnt_o}, 32'h0);
    tick();
    bus.m0_req_i   = 1'b0;
    bus.s_rvalid_i = 1'b1;
    #1;
    check("lock_m1_gnt_after", {31'h0, bus.m1_gnt_o}, 32'h1);
    check("lock_m1_addr_after", bus.s_addr_o, 32'h200);
    check("lock_rsp0_m0", {31'h0, bus.m0_rvalid_o}, 32'h1);
    tick();
    bus.m1_req_i = 1'b0;
    bus.s_gnt_i  = 1'b0;
    #1;
    check("lock_rsp1_m1", {31'h0, bus.m1_rvalid_o}, 32'h1);
    tick();
    bus.s_rvalid_i = 1'b0;
    #1;
    check("lock_drained", {30'h0, outstanding}, 32'h0);

    // Full and in-order return with depth 2.
    do_reset();
    bus.m0_req_i = 1'b1;
    bus.s_gnt_i  = 1'b1;
    tick();
    bus.m0_req_i = 1'b0;
    bus.m1_req_i = 1'b1;
    #1;
    check("full_m1_gnt", {31'h0, bus.m1_gnt_o}, 32'h1);
    tick();
    bus.m1_req_i = 1'b0;
    bus.m0_req_i = 1'b1;
    #1;
    check("full_outstanding", {30'h0, outstanding}, 32'h2);
    check("full_s_req", {31'h0, bus.s_req_o}, 32'h0);
    check("full_m0_gnt", {31'h0, bus.m0_gnt_o}, 32'h0);
    tick();
    bus.s_rvalid_i = 1'b1;
    #1;
    check("full_rsp0_m0", {31'h0, bus.m0_rvalid_o}, 32'h1);
    check("full_rsp0_m1", {31'h0, bus.m1_rvalid_o}, 32'h0);
    check("full_pushpop_gnt", {31'h0, bus.m0_gnt_o}, 32'h1);
    tick();
    bus.m0_req_i = 1'b0;
    bus.s_gnt_i  = 1'b0;
    #1;
    check("full_pushpop_cnt", {30'h0, outstanding}, 32'h2);
    check("full_rsp1_m1", {31'h0, bus.m1_rvalid_o}, 32'h1);
    check("full_rsp1_m0", {31'h0, bus.m0_rvalid_o}, 32'h0);
    tick();
    #1;
    check("full_rsp2_m0", {31'h0, bus.m0_rvalid_o}, 32'h1);
    check("full_cnt_1", {30'h0, outstanding}, 32'h1);
    tick();
    bus.s_rvalid_i = 1'b0;
    #1;
    check("full_cnt_0", {30'h0, outstanding}, 32'h0);

    // Error: response with nothing outstanding.
    do_reset();
    bus.s_rvalid_i = 1'b1;
    #1;
    check("err_same_cycle", {31'h0, err}, 32'h0);
    check("err_m0_rvalid", {31'h0, bus.m0_rvalid_o}, 32'h0);
    check("err_m1_rvalid", {31'h0, bus.m1_rvalid_o}, 32'h0);
    tick();
    bus.s_rvalid_i = 1'b0;
    #1;
    check("err_set", {31'h0, err}, 32'h1);
    check("err_no_underflow", {30'h0, outstanding}, 32'h0);
    tick();
    #1;
    check("err_sticky", {31'h0, err}, 32'h1);
    tick();
    rst = 1'b1;
    #1;
    check("err_during_rst", {31'h0, err}, 32'h0);
    tick();
    rst = 1'b0;
    #1;
    check("err_cleared", {31'h0, err}, 32'h0);

    // Mid-operation reset with two transfers in flight.
    do_reset();
    bus.m0_req_i = 1'b1;
    bus.s_gnt_i  = 1'b1;
    tick();
    bus.m0_req_i = 1'b0;
    bus.m1_req_i = 1'b1;
    tick();
    #1;
    check("mid_outstanding", {30'h0, outstanding}, 32'h2);
    tick();
    rst = 1'b1;
    bus.m0_req_i = 1'b1;
    #1;
    check("mid_rst_m0_gnt", {31'h0, bus.m0_gnt_o}, 32'h0);
    check("mid_rst_m1_gnt", {31'h0, bus.m1_gnt_o}, 32'h0);
    tick();
    idle_inputs();
    rst = 1'b0;
    #1;
    check("mid_after_outstanding", {30'h0, outstanding}, 32'h0);
    tick();
    single_fetch("refetch");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
